// File: rtl/fb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fb_pkg : frame-buffer geometry, lane widths and packer state type     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package fb_pkg;

  localparam int unsigned H_PIX  = 640;
  localparam int unsigned V_PIX  = 480;
  localparam int unsigned WORDS  = H_PIX * V_PIX / 4;
  localparam int unsigned ADDR_W = 19;

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 2;
  localparam int unsigned HOLD_W = (LANES - 1) * PIX_W;
  localparam int unsigned WORD_W = LANES * PIX_W;

  localparam logic [PIX_W-1:0] FILL = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Keep the first 'filled' lanes of the holding register, pad the rest.
  function automatic logic [WORD_W-1:0] fill_word(
    input logic [HOLD_W-1:0] hold,
    input logic [LANE_W-1:0] filled,
    input logic [PIX_W-1:0]  fill
  );
    logic [WORD_W-1:0] w;
    w = {LANES{fill}};
    for (int i = 0; i < int'(LANES) - 1; i++) begin
      if (LANE_W'(i) < filled) w[PIX_W*i +: PIX_W] = hold[PIX_W*i +: PIX_W];
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_pixel_packer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fb_pixel_packer_if : pixel stream in, frame RAM write port out        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface fb_pixel_packer_if;
  import fb_pkg::*;

  logic [PIX_W-1:0]  i_pix;
  logic              i_valid;
  logic              i_sof;
  logic              i_flush;
  logic              i_clr_err;
  logic              o_ready;
  logic              o_we;
  logic [ADDR_W-1:0] o_addr;
  logic [WORD_W-1:0] o_wd;
  logic              o_frame_done;
  logic              o_short_frame;

  modport master (
    output i_pix, i_valid, i_sof, i_flush, i_clr_err,
    input  o_ready, o_we, o_addr, o_wd, o_frame_done, o_short_frame
  );

  modport slave (
    input  i_pix, i_valid, i_sof, i_flush, i_clr_err,
    output o_ready, o_we, o_addr, o_wd, o_frame_done, o_short_frame
  );
endinterface
`default_nettype wire

// File: rtl/fb_pixel_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fb_pixel_packer : packs 4 palette indices per 32-bit frame RAM word   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module fb_pixel_packer #(
  parameter int unsigned H_PIX = fb_pkg::H_PIX,
  parameter int unsigned V_PIX = fb_pkg::V_PIX,
  parameter logic [7:0]  FILL  = fb_pkg::FILL
) (
  input  wire               iVGA_CLK,
  input  wire               iRST_n,
  fb_pixel_packer_if.slave  bus
);
  import fb_pkg::*;

  localparam int unsigned FRAME_WORDS = H_PIX * V_PIX / 4;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  state_t             state, state_n;
  logic [LANE_W-1:0]  lane, lane_n;
  logic [ADDR_W-1:0]  waddr, waddr_n;
  logic [HOLD_W-1:0]  hold, hold_n;
  logic               short_r, short_n;
  logic               we_r, we_n;
  logic [ADDR_W-1:0]  addr_r, addr_n;
  logic [WORD_W-1:0]  wd_r, wd_n;
  logic               done_r, done_n;
  logic               ready;
  logic               accept;
  logic               at_last;

  assign ready   = (state != FLUSH);
  assign accept  = bus.i_valid & ready;
  assign at_last = (waddr == LAST_ADDR);

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state   <= IDLE;
      lane    <= '0;
      waddr   <= '0;
      hold    <= '0;
      short_r <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wd_r    <= '0;
      done_r  <= 1'b0;
    end else begin
      state   <= state_n;
      lane    <= lane_n;
      waddr   <= waddr_n;
      hold    <= hold_n;
      short_r <= short_n;
      we_r    <= we_n;
      addr_r  <= addr_n;
      wd_r    <= wd_n;
      done_r  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    lane_n  = lane;
    waddr_n = waddr;
    hold_n  = hold;
    short_n = short_r & ~bus.i_clr_err;
    we_n    = 1'b0;
    addr_n  = addr_r;
    wd_n    = wd_r;
    done_n  = 1'b0;

    case (state)
      IDLE: begin
        if (accept && bus.i_sof) begin
          hold_n[PIX_W-1:0] = bus.i_pix;
          lane_n            = LANE_W'(1);
          waddr_n           = '0;
          state_n           = PACK;
        end
      end

      PACK: begin
        if (accept) begin
          if (bus.i_sof) begin
            // Restart the frame; the partial word is abandoned, never written.
            short_n           = 1'b1;
            hold_n[PIX_W-1:0] = bus.i_pix;
            lane_n            = LANE_W'(1);
            waddr_n           = '0;
          end else if (lane != LANE_W'(3)) begin
            hold_n[{lane, 3'b000} +: PIX_W] = bus.i_pix;
            lane_n                          = lane + LANE_W'(1);
          end else begin
            we_n   = 1'b1;
            addr_n = waddr;
            wd_n   = {bus.i_pix, hold};
            lane_n = '0;
            if (at_last) begin
              done_n  = 1'b1;
              waddr_n = '0;
              state_n = IDLE;
            end else begin
              waddr_n = waddr + ADDR_W'(1);
            end
          end
        end
        // Flush looks at the lane count after this cycle's pixel is absorbed.
        if (bus.i_flush && (lane_n != '0) && (state_n == PACK)) state_n = FLUSH;
      end

      FLUSH: begin
        we_n   = 1'b1;
        addr_n = waddr;
        wd_n   = fill_word(hold, lane, FILL);
        lane_n = '0;
        if (at_last) begin
          done_n  = 1'b1;
          waddr_n = '0;
          state_n = IDLE;
        end else begin
          waddr_n = waddr + ADDR_W'(1);
          state_n = PACK;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign bus.o_ready       = ready;
  assign bus.o_we          = we_r;
  assign bus.o_addr        = addr_r;
  assign bus.o_wd          = wd_r;
  assign bus.o_frame_done  = done_r;
  assign bus.o_short_frame = short_r;

endmodule
`default_nettype wire

// File: tb/tb_fb_pixel_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fb_pixel_packer : directed self-checking bench, 8x4 pixel frame    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_fb_pixel_packer;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  fb_pixel_packer_if bus();

  // Small frame: 8x4 pixels -> 8 words, so the wrap is reachable quickly.
  fb_pixel_packer #(
    .H_PIX (8),
    .V_PIX (4),
    .FILL  (8'h00)
  ) dut (
    .iVGA_CLK (clk),
    .iRST_n   (rst_n),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [7:0] p, input logic sof, input logic flush, input logic clr);
    bus.i_pix     = p;
    bus.i_valid   = 1'b1;
    bus.i_sof     = sof;
    bus.i_flush   = flush;
    bus.i_clr_err = clr;
    @(posedge clk);
    #1;
    bus.i_valid   = 1'b0;
    bus.i_sof     = 1'b0;
    bus.i_flush   = 1'b0;
    bus.i_clr_err = 1'b0;
  endtask

  task automatic idle(input logic flush, input logic clr);
    bus.i_valid   = 1'b0;
    bus.i_flush   = flush;
    bus.i_clr_err = clr;
    @(posedge clk);
    #1;
    bus.i_flush   = 1'b0;
    bus.i_clr_err = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_wd;
    int          writes;
    compared   = 0;
    mismatched = 0;
    bus.i_pix = '0; bus.i_valid = 0; bus.i_sof = 0; bus.i_flush = 0; bus.i_clr_err = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we",    bus.o_we, 0);
    chk("rst_addr",  bus.o_addr, 0);
    chk("rst_wd",    bus.o_wd, 0);
    chk("rst_done",  bus.o_frame_done, 0);
    chk("rst_short", bus.o_short_frame, 0);
    chk("rst_ready", bus.o_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Non-SOF beats in IDLE are dropped.
    writes = 0;
    for (int i = 0; i < 5; i++) begin
      beat(8'h55 + 8'(i), 0, 0, 0);
      writes += int'(bus.o_we);
    end
    chk("idle_drop_writes", 32'(writes), 0);

    // First word of the frame.
    beat(8'h11, 1, 0, 0);
    beat(8'h22, 0, 0, 0);
    beat(8'h33, 0, 0, 0);
    chk("w0_not_yet", bus.o_we, 0);
    beat(8'h44, 0, 0, 0);
    chk("w0_we",   bus.o_we, 1);
    chk("w0_addr", bus.o_addr, 0);
    chk("w0_wd",   bus.o_wd, 32'h44332211);
    chk("w0_done", bus.o_frame_done, 0);
    idle(0, 0);
    chk("w0_we_drop",  bus.o_we, 0);
    chk("w0_wd_hold",  bus.o_wd, 32'h44332211);

    // Remaining words 1..7; only the last carries frame_done.
    for (int w = 1; w < 8; w++) begin
      for (int j = 0; j < 4; j++) begin
        beat(8'(w * 16 + j), 0, 0, 0);
        exp_wd[8*j +: 8] = 8'(w * 16 + j);
      end
      chk("frame_we",   bus.o_we, 1);
      chk("frame_addr", bus.o_addr, 32'(w));
      chk("frame_wd",   bus.o_wd, exp_wd);
      chk("frame_done", bus.o_frame_done, (w == 7) ? 1 : 0);
    end
    idle(0, 0);
    chk("done_pulse_end", bus.o_frame_done, 0);
    chk("addr_hold_last", bus.o_addr, 7);

    // Back in IDLE: non-SOF beats must not produce a write.
    writes = 0;
    for (int i = 0; i < 4; i++) begin
      beat(8'hF0 + 8'(i), 0, 0, 0);
      writes += int'(bus.o_we);
    end
    chk("post_frame_idle", 32'(writes), 0);

    // Partial flush: three filled lanes, top lane padded.
    beat(8'h01, 1, 0, 0);
    beat(8'hAA, 0, 0, 0);
    beat(8'hBB, 0, 0, 0);
    idle(1, 0);
    chk("flush_ready_low", bus.o_ready, 0);
    chk("flush_no_we_yet", bus.o_we, 0);
    idle(0, 0);
    chk("flush_we",    bus.o_we, 1);
    chk("flush_addr",  bus.o_addr, 0);
    chk("flush_wd",    bus.o_wd, 32'h00BBAA01);
    chk("flush_ready", bus.o_ready, 1);
    beat(8'h91, 0, 0, 0);
    beat(8'h92, 0, 0, 0);
    beat(8'h93, 0, 0, 0);
    beat(8'h94, 0, 0, 0);
    chk("after_flush_addr", bus.o_addr, 1);
    chk("after_flush_wd",   bus.o_wd, 32'h94939291);

    // Flush with lane==0 is ignored.
    idle(1, 0);
    chk("flush_lane0_ready", bus.o_ready, 1);

    // SOF while packing flags a short frame and restarts at address 0.
    beat(8'hA0, 1, 0, 0);
    chk("short_set", bus.o_short_frame, 1);
    beat(8'hA1, 0, 0, 0);
    beat(8'hA2, 0, 0, 0);
    beat(8'hA3, 0, 0, 0);
    chk("q_addr", bus.o_addr, 0);
    chk("q_wd",   bus.o_wd, 32'hA3A2A1A0);
    beat(8'hA4, 0, 0, 0);
    beat(8'hA5, 0, 0, 0);
    beat(8'hB0, 1, 0, 0);
    chk("short_no_write", bus.o_we, 0);
    beat(8'hB1, 0, 0, 0);
    beat(8'hB2, 0, 0, 0);
    beat(8'hB3, 0, 0, 0);
    chk("r_we",   bus.o_we, 1);
    chk("r_addr", bus.o_addr, 0);
    chk("r_wd",   bus.o_wd, 32'hB3B2B1B0);
    chk("short_sticky", bus.o_short_frame, 1);

    // Set beats clear in the same cycle; a lone clear then drops the flag.
    beat(8'hC0, 1, 0, 1);
    chk("short_set_wins", bus.o_short_frame, 1);
    idle(0, 1);
    chk("short_cleared", bus.o_short_frame, 0);

    // Flush together with the 4th pixel: one full write, no FLUSH cycle.
    beat(8'hC1, 0, 0, 0);
    beat(8'hC2, 0, 0, 0);
    beat(8'hC3, 0, 1, 0);
    chk("full_flush_we",    bus.o_we, 1);
    chk("full_flush_addr",  bus.o_addr, 0);
    chk("full_flush_wd",    bus.o_wd, 32'hC3C2C1C0);
    chk("full_flush_ready", bus.o_ready, 1);
    idle(0, 0);
    chk("full_flush_no_extra", bus.o_we, 0);

    // Asynchronous reset in the middle of a word.
    beat(8'hD0, 1, 0, 0);
    beat(8'hD1, 0, 0, 0);
    chk("pre_rst_short", bus.o_short_frame, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we",    bus.o_we, 0);
    chk("mid_rst_addr",  bus.o_addr, 0);
    chk("mid_rst_wd",    bus.o_wd, 0);
    chk("mid_rst_short", bus.o_short_frame, 0);
    chk("mid_rst_ready", bus.o_ready, 1);
    @(posedge clk); #1;
    chk("mid_rst_hold_we", bus.o_we, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    beat(8'hE0, 1, 0, 0);
    beat(8'hE1, 0, 0, 0);
    beat(8'hE2, 0, 0, 0);
    beat(8'hE3, 0, 0, 0);
    chk("post_rst_addr", bus.o_addr, 0);
    chk("post_rst_wd",   bus.o_wd, 32'hE3E2E1E0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
